imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Write-side companion to inst_mem. It receives a program as a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit words. Each word is written into instruction memory at consecutive word addresses starting from 0. While a load is in progress the block holds the RV32I core in reset, and it releases the core once the program is in memory.

Parameters:
DEPTH, 32, instruction memory depth in words; also the maximum number of words per load
AW, 32, width of the memory address (word index, same indexing as the IMEMaddr read port)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load; honoured only in IDLE or DONE
num_words  input  AW  number of words to load; sampled on start
byte_valid  input  1  byte_data is valid
byte_data  input  8  program byte; first byte of each word is bits [7:0]
byte_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  one-cycle write strobe to instruction memory
imem_waddr  output  AW  word index being written
imem_wdata  output  32  assembled instruction word
busy  output  1  high in LOAD and WRITE
done  output  1  high in DONE
overflow  output  1  num_words exceeded DEPTH on the last start (sticky until next start)
cpu_rst_n  output  1  reset to the core; low except in DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all of byte_ready, imem_we, imem_waddr, imem_wdata, busy, done, overflow, byte counter and word index are 0.
  - cpu_rst_n=0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - start=1 latches the target word count; next state is LOAD.
  - If num_words=0, the next state is DONE directly.
  - If num_words>DEPTH, the target is clamped to DEPTH and overflow=1.
  - Every start clears overflow first, then sets it only if the new num_words>DEPTH.
- LOAD:
  - byte_ready=1.
  - On each edge with byte_valid&byte_ready, byte k (k=0..3) is stored into wdata[8k+7:8k] and the byte counter increments.
  - On acceptance of byte 3, the byte counter wraps to 0 and the next state is WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0, imem_we=1, imem_waddr=word index, imem_wdata=assembled word.
  - At the next edge the word index increments.
  - If the incremented index equals the target count, next state is DONE; otherwise LOAD.
- DONE:
  - done=1, cpu_rst_n=1, byte_ready=0.
  - imem_waddr holds the last written index, imem_wdata holds the last word.
  - start=1 begins a new load:
    - word index returns to 0 and cpu_rst_n drops to 0 the following cycle;
    - the overflow and num_words=0 rules from IDLE apply.
- Latency:
  - start at edge N puts byte_ready=1 from cycle N+1.
  - 4th byte accepted at edge E gives imem_we=1 in cycle E+1.
  - With continuous valid, one word takes 5 cycles.
- Ignored inputs:
  - start in LOAD or WRITE is ignored.
  - byte_valid in IDLE, WRITE or DONE is ignored; no byte is consumed.
- Stalls: when byte_valid drops mid-word, partial bytes are retained with no timeout.
- imem_wdata is only meaningful while imem_we=1. Stale upper bytes are overwritten before the strobe, so no clearing between words is required.
- Word index width: internal index is $clog2(DEPTH)+1 bits, zero-extended onto imem_waddr.
- Reset mid-load: everything returns to the reset values immediately.
  - Words already written stay in memory; the loader does not clear them.
  - cpu_rst_n stays 0.

Decomposition:
- Shared package rv32i_pkg:
  - typedef enum logic [1:0] loader_state_t {IDLE, LOAD, WRITE, DONE};
  - localparam XLEN=32.
  - Byte lane width constant (8) and bytes-per-word constant (4).
- One natural sub-module, byte_packer:
  - 2-bit byte counter plus 32-bit shift/insert register;
  - outputs word_ready on the 4th accepted byte.
- The FSM, word index, clamp logic and output registers stay in imem_loader.

Test Plan:
- Single word: reset, start with num_words=1, bytes 05,00,00,00 sent back-to-back.
  - Required: imem_we=1 for exactly one cycle, imem_waddr=0, imem_wdata=32'h00000005.
  - Then done=1 and cpu_rst_n=1 one cycle later.
- Multi-word streaming: num_words=3, words 5, 10, 15 sent with continuous valid.
  - Required: three strobes at addresses 0,1,2 with data 5, 10, 15, spaced 5 cycles apart.
  - byte_ready=0 during each WRITE cycle; busy=1 throughout the load.
- Stalled source: byte_valid toggled 1,0,0,1,1,0,1 while sending bytes EF,BE,AD,DE.
  - Required: a single write of 32'hDEADBEEF at address 0; no byte lost or duplicated.
- Boundaries:
  - num_words=0: DONE is reached the cycle after start and imem_we never asserts.
  - num_words=40 with DEPTH=32: overflow=1, exactly 32 writes at addresses 0..31, then done.
- Mid-load events:
  - start pulsed in LOAD after 2 bytes: ignored, the word completes normally.
  - rst_n driven low after 2 of 4 words: all outputs return to reset values asynchronously, cpu_rst_n=0.
  - A following start reloads from address 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I instruction-memory loader.
// Latency: n/a. Backpressure: n/a.
package rv32i_pkg;

    localparam int XLEN           = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = XLEN / BYTE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word.
// Latency: the word is complete on the edge that accepts byte 3. Backpressure: none; the parent gates accept.
module byte_packer
    import rv32i_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [XLEN-1:0]   word,
    output logic              word_ready
);

    logic [1:0] cnt;

    // No clearing between words: every lane is rewritten before the next strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 2'd0;
            word <= '0;
        end else if (accept) begin
            word[{cnt, 3'b000} +: BYTE_W] <= byte_data;
            cnt                           <= cnt + 2'd1;
        end
    end

    assign word_ready = accept && (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory and holds the core in reset until loaded.
// Latency: 5 cycles per word with continuous valid. Backpressure: byte_ready only in LOAD.
module imem_loader
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     num_words,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [AW-1:0]     imem_waddr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              cpu_rst_n
);

    localparam int IW = $clog2(DEPTH) + 1;

    loader_state_t   state, next_state;
    logic [IW-1:0]   widx;
    logic [IW-1:0]   widx_inc;
    logic [IW-1:0]   tgt;
    logic [IW-1:0]   waddr_q;
    logic            accept;
    logic            start_ok;
    logic            word_ready;
    logic [XLEN-1:0] word;

    assign accept   = byte_valid && byte_ready;
    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign widx_inc = widx + IW'(1);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept     (accept),
        .byte_data  (byte_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            widx     <= '0;
            tgt      <= '0;
            waddr_q  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= next_state;
            if (start_ok) begin
                widx <= '0;
                if (num_words > AW'(DEPTH)) begin
                    tgt      <= IW'(DEPTH);
                    overflow <= 1'b1;
                end else begin
                    tgt      <= num_words[IW-1:0];
                    overflow <= 1'b0;
                end
            end
            // Captured on the last byte so the address survives into DONE.
            if (word_ready) begin
                waddr_q <= widx;
            end
            if (state == WRITE) begin
                widx <= widx_inc;
            end
        end
    end

    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cpu_rst_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) next_state = (num_words == '0) ? DONE : LOAD;
            end
            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (word_ready) next_state = WRITE;
            end
            WRITE: begin
                imem_we    = 1'b1;
                busy       = 1'b1;
                next_state = (widx_inc == tgt) ? DONE : LOAD;
            end
            DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
                if (start) next_state = (num_words == '0) ? DONE : LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    assign imem_waddr = AW'(waddr_q);
    assign imem_wdata = word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streaming, stalls, boundaries, mid-load start and reset.
module tb_imem_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start = 1'b0;
    logic [AW-1:0] num_words = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          cpu_rst_n;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .cpu_rst_n  (cpu_rst_n)
    );

    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int rdy_bad = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write log; a strobe must never coincide with byte_ready, !busy or done.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            wr_addr.push_back(imem_waddr);
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
            if (byte_ready || !busy || done) rdy_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clr_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic pulse_start(input logic [31:0] n);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) check("byte_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic idle_cyc();
        byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_imem_we",    {31'd0, imem_we},    32'd0);
        check("rst_waddr",      imem_waddr,          32'd0);
        check("rst_wdata",      imem_wdata,          32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_done",       {31'd0, done},       32'd0);
        check("rst_overflow",   {31'd0, overflow},   32'd0);
        check("rst_cpu_rst_n",  {31'd0, cpu_rst_n},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);

        // num_words = 0: DONE the cycle after start, no write
        clr_log();
        pulse_start(32'd0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("zero_writes", wr_addr.size(), 32'd0);

        // Single word
        clr_log();
        pulse_start(32'd1);
        check("single_cpu_rst_low", {31'd0, cpu_rst_n},  32'd0);
        check("single_ready_n1",    {31'd0, byte_ready}, 32'd1);
        send_word(32'h0000_0005);
        check("single_we",    {31'd0, imem_we},    32'd1);
        check("single_waddr", imem_waddr,          32'd0);
        check("single_wdata", imem_wdata,          32'h0000_0005);
        check("single_rdy_0", {31'd0, byte_ready}, 32'd0);
        @(negedge clk);
        check("single_we_off", {31'd0, imem_we},   32'd0);
        check("single_done",   {31'd0, done},      32'd1);
        check("single_cpu_on", {31'd0, cpu_rst_n}, 32'd1);
        check("single_nwr",    wr_addr.size(),     32'd1);

        // Multi-word streaming
        clr_log();
        pulse_start(32'd3);
        check("multi_busy",    {31'd0, busy},      32'd1);
        check("multi_cpu_off", {31'd0, cpu_rst_n}, 32'd0);
        send_word(32'd5);
        send_word(32'd10);
        send_word(32'd15);
        wait_done(5);
        check("multi_nwr", wr_addr.size(), 32'd3);
        if (wr_addr.size() == 3) begin
            check("multi_a0", wr_addr[0], 32'd0);
            check("multi_a1", wr_addr[1], 32'd1);
            check("multi_a2", wr_addr[2], 32'd2);
            check("multi_d0", wr_data[0], 32'd5);
            check("multi_d1", wr_data[1], 32'd10);
            check("multi_d2", wr_data[2], 32'd15);
            check("multi_gap1", wr_cyc[1] - wr_cyc[0], 32'd5);
            check("multi_gap2", wr_cyc[2] - wr_cyc[1], 32'd5);
        end

        // Stalled source: valid pattern 1,0,0,1,1,0,1
        clr_log();
        pulse_start(32'd1);
        send_byte(8'hEF);
        idle_cyc();
        idle_cyc();
        send_byte(8'hBE);
        send_byte(8'hAD);
        idle_cyc();
        send_byte(8'hDE);
        check("stall_we",    {31'd0, imem_we}, 32'd1);
        check("stall_wdata", imem_wdata,       32'hDEAD_BEEF);
        check("stall_waddr", imem_waddr,       32'd0);
        wait_done(5);
        check("stall_nwr", wr_addr.size(), 32'd1);

        // start in LOAD after 2 bytes is ignored
        clr_log();
        pulse_start(32'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        start     = 1'b1;
        num_words = 32'd5;
        @(negedge clk);
        start     = 1'b0;
        send_byte(8'h33);
        send_byte(8'h44);
        @(negedge clk);
        check("midstart_done", {31'd0, done}, 32'd1);
        check("midstart_nwr",  wr_addr.size(), 32'd1);
        if (wr_data.size() == 1) check("midstart_data", wr_data[0], 32'h4433_2211);

        // Overflow: 40 requested, 32 written
        clr_log();
        pulse_start(32'd40);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < DEPTH; i++) send_word(32'hA500_0000 + i);
        wait_done(5);
        check("ovf_nwr", wr_addr.size(), 32'd32);
        if (wr_addr.size() == 32) begin
            for (int i = 0; i < DEPTH; i++) begin
                check("ovf_addr", wr_addr[i], i);
                check("ovf_data", wr_data[i], 32'hA500_0000 + i);
            end
        end
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        pulse_start(32'd2);
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        send_word(32'h1);
        send_word(32'h2);
        wait_done(5);

        // Reset mid-load, then reload from address 0
        clr_log();
        pulse_start(32'd4);
        send_word(32'hCAFE_0001);
        send_word(32'hCAFE_0002);
        send_byte(8'h77);
        check("rml_nwr", wr_addr.size(), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rml_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rml_imem_we",    {31'd0, imem_we},    32'd0);
        check("rml_waddr",      imem_waddr,          32'd0);
        check("rml_wdata",      imem_wdata,          32'd0);
        check("rml_busy",       {31'd0, busy},       32'd0);
        check("rml_done",       {31'd0, done},       32'd0);
        check("rml_overflow",   {31'd0, overflow},   32'd0);
        check("rml_cpu_rst_n",  {31'd0, cpu_rst_n},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clr_log();
        pulse_start(32'd1);
        send_word(32'h600D_F00D);
        check("reload_waddr", imem_waddr, 32'd0);
        check("reload_wdata", imem_wdata, 32'h600D_F00D);
        wait_done(5);
        check("reload_nwr", wr_addr.size(), 32'd1);

        check("write_cycle_ready_busy", rdy_bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
